// File: rtl/register_file_32x32_pkg.sv
// rtl/register_file_32x32_pkg.sv - shared widths, types and helpers for the 32x32 register file
package register_file_32x32_pkg;

   localparam int unsigned REG_DATA_WIDTH = 32;
   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned REG_COUNT      = 32;
   localparam logic [REG_DATA_WIDTH-1:0] REG_RESET_VALUE = 32'h0;

   typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [REG_COUNT-1:0][REG_DATA_WIDTH-1:0] reg_bank_t;

   // True when an index refers to the hard-wired zero register.
   function automatic logic is_zero_reg(input reg_addr_t addr, input logic zero_en);
      return zero_en && (addr == '0);
   endfunction

endpackage

// File: rtl/MUX32_32x1.sv
// rtl/MUX32_32x1.sv - 32-input, 32-bit wide multiplexer
module MUX32_32x1
   import register_file_32x32_pkg::*;
(
   input  reg_bank_t data_i,
   input  reg_addr_t sel_i,
   output reg_data_t data_o
);

   assign data_o = data_i[sel_i];

endmodule

// File: rtl/decoder_5x32.sv
// rtl/decoder_5x32.sv - 5-bit index to 32-bit one-hot with enable
module decoder_5x32
   import register_file_32x32_pkg::*;
(
   input  logic                 en_i,
   input  reg_addr_t            addr_i,
   output logic [REG_COUNT-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[addr_i] = 1'b1;
      end
   end

endmodule

// File: rtl/register_file_32x32.sv
// rtl/register_file_32x32.sv - 32x32 register file, two registered read ports, one write port
module register_file_32x32
   import register_file_32x32_pkg::*;
#(
   parameter logic ZERO_REG = 1'b1
)(
   input  logic      CLK,
   input  logic      RST,
   input  logic      READ,
   input  logic      WRITE,
   input  reg_addr_t ADDR_R1,
   input  reg_addr_t ADDR_R2,
   input  reg_addr_t ADDR_W,
   input  reg_data_t DATA_W,
   output reg_data_t DATA_R1,
   output reg_data_t DATA_R2
);

   reg_bank_t              regs_q;
   logic [REG_COUNT-1:0]   wr_onehot;
   logic [REG_COUNT-1:0]   wr_en;
   reg_data_t              mux_r1;
   reg_data_t              mux_r2;
   reg_data_t              data_r1_d, data_r1_q;
   reg_data_t              data_r2_d, data_r2_q;

   decoder_5x32 u_wr_dec (
      .en_i     (WRITE),
      .addr_i   (ADDR_W),
      .onehot_o (wr_onehot)
   );

   // Register 0 never receives a write enable when it is hard-wired to zero.
   always_comb begin
      wr_en = wr_onehot;
      if (ZERO_REG) begin
         wr_en[0] = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= REG_RESET_VALUE;
         end
      end else begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (wr_en[i]) begin
               regs_q[i] <= DATA_W;
            end
         end
      end
   end

   MUX32_32x1 u_mux_r1 (
      .data_i (regs_q),
      .sel_i  (ADDR_R1),
      .data_o (mux_r1)
   );

   MUX32_32x1 u_mux_r2 (
      .data_i (regs_q),
      .sel_i  (ADDR_R2),
      .data_o (mux_r2)
   );

   // Zero register wins over bypass; bypass wins over the stored value.
   always_comb begin
      data_r1_d = mux_r1;
      if (is_zero_reg(ADDR_R1, ZERO_REG)) begin
         data_r1_d = REG_RESET_VALUE;
      end else if (WRITE && (ADDR_W == ADDR_R1)) begin
         data_r1_d = DATA_W;
      end
   end

   always_comb begin
      data_r2_d = mux_r2;
      if (is_zero_reg(ADDR_R2, ZERO_REG)) begin
         data_r2_d = REG_RESET_VALUE;
      end else if (WRITE && (ADDR_W == ADDR_R2)) begin
         data_r2_d = DATA_W;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         data_r1_q <= REG_RESET_VALUE;
         data_r2_q <= REG_RESET_VALUE;
      end else if (READ) begin
         data_r1_q <= data_r1_d;
         data_r2_q <= data_r2_d;
      end
   end

   assign DATA_R1 = data_r1_q;
   assign DATA_R2 = data_r2_q;

endmodule

// File: tb/tb_register_file_32x32.sv
// tb/tb_register_file_32x32.sv - directed self-checking bench for register_file_32x32
module tb_register_file_32x32;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd;
   logic        wr;
   logic [4:0]  addr_r1;
   logic [4:0]  addr_r2;
   logic [4:0]  addr_w;
   logic [31:0] data_w;
   logic [31:0] z_r1, z_r2;
   logic [31:0] n_r1, n_r2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   register_file_32x32 #(.ZERO_REG(1'b1)) u_dut_z (
      .CLK     (clk),
      .RST     (rst),
      .READ    (rd),
      .WRITE   (wr),
      .ADDR_R1 (addr_r1),
      .ADDR_R2 (addr_r2),
      .ADDR_W  (addr_w),
      .DATA_W  (data_w),
      .DATA_R1 (z_r1),
      .DATA_R2 (z_r2)
   );

   register_file_32x32 #(.ZERO_REG(1'b0)) u_dut_n (
      .CLK     (clk),
      .RST     (rst),
      .READ    (rd),
      .WRITE   (wr),
      .ADDR_R1 (addr_r1),
      .ADDR_R2 (addr_r2),
      .ADDR_W  (addr_w),
      .DATA_W  (data_w),
      .DATA_R1 (n_r1),
      .DATA_R2 (n_r2)
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] aw, input logic [31:0] dw);
      rd      = r;
      wr      = w;
      addr_r1 = a1;
      addr_r2 = a2;
      addr_w  = aw;
      data_w  = dw;
   endtask

   task automatic check4(input string tag, input logic [31:0] ez1, input logic [31:0] ez2,
                         input logic [31:0] en1, input logic [31:0] en2);
      check_vec({tag, " z.r1"}, z_r1, ez1);
      check_vec({tag, " z.r2"}, z_r2, ez2);
      check_vec({tag, " n.r1"}, n_r1, en1);
      check_vec({tag, " n.r2"}, n_r2, en2);
   endtask

   initial begin
      logic [31:0] e1, e2;

      // Reset held two edges while a write is requested
      rst = 1'b1;
      drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF);
      step();
      step();
      check4("reset", 32'h0, 32'h0, 32'h0, 32'h0);
      rst = 1'b0;
      drive(1'b1, 1'b0, 5'd5, 5'd31, 5'd0, 32'h0);
      step();
      check4("post-reset read", 32'h0, 32'h0, 32'h0, 32'h0);

      // Write then read
      drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h1234_5678);
      step();
      drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd31, 32'hA5A5_A5A5);
      step();
      drive(1'b1, 1'b0, 5'd7, 5'd31, 5'd0, 32'h0);
      step();
      check4("wr-rd", 32'h1234_5678, 32'hA5A5_A5A5, 32'h1234_5678, 32'hA5A5_A5A5);

      // Bypass on same edge
      drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0000_0001);
      step();
      drive(1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 32'h0BAD_F00D);
      step();
      check4("bypass", 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D);
      drive(1'b1, 1'b0, 5'd9, 5'd9, 5'd0, 32'h0);
      step();
      check4("bypass follow", 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D);

      // Bypass on one port, independent stored value on the other
      drive(1'b1, 1'b1, 5'd31, 5'd12, 5'd12, 32'h5555_AAAA);
      step();
      check4("bypass indep", 32'hA5A5_A5A5, 32'h5555_AAAA, 32'hA5A5_A5A5, 32'h5555_AAAA);

      // Zero register
      drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
      step();
      check4("r0 bypass", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
      step();
      check4("r0 read", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Hold with READ=0 while writing the register a port points at
      drive(1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0);
      step();
      check4("hold pre", 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
      drive(1'b0, 1'b1, 5'd31, 5'd7, 5'd7, 32'hCAFE_BABE);
      step();
      check4("hold", 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);

      // Mid-sequence reset overrides READ and WRITE
      rst = 1'b1;
      drive(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 32'h7777_7777);
      step();
      check4("mid reset", 32'h0, 32'h0, 32'h0, 32'h0);
      rst = 1'b0;
      drive(1'b1, 1'b0, 5'd7, 5'd9, 5'd0, 32'h0);
      step();
      check4("post mid reset", 32'h0, 32'h0, 32'h0, 32'h0);

      // Sweep: Ri = i * 0x01010101, then read pairs (i, 31-i)
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b1, 5'd0, 5'd0, 5'(i), 32'(i) * 32'h0101_0101);
         step();
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0);
         step();
         e1 = 32'(i) * 32'h0101_0101;
         e2 = 32'(31 - i) * 32'h0101_0101;
         check_vec($sformatf("sweep z.r1 i=%0d", i), z_r1, (i == 0) ? 32'h0 : e1);
         check_vec($sformatf("sweep z.r2 i=%0d", i), z_r2, (i == 31) ? 32'h0 : e2);
         check_vec($sformatf("sweep n.r1 i=%0d", i), n_r1, e1);
         check_vec($sformatf("sweep n.r2 i=%0d", i), n_r2, e2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
